// File: rtl/mult_sched_if.sv
// Requester and response channels of the multiplier scheduler.
// master = requesters plus response consumer, slave = the scheduler.
interface mult_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product, rsp_err
  );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one start/done multiplier between NREQ requesters,
// with a watchdog that turns a missing done into an error response.
module mult_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_sched_if.slave        bus,
  output logic               busy,
  output logic               mult_start,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_product
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, BLANK, WAIT, RESP} state_t;

  state_t             state_reg, state_next;
  logic [IDW-1:0]     last_reg, last_next;
  logic [IDW-1:0]     id_reg, id_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               start_reg, start_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0]     rsp_id_reg, rsp_id_next;
  logic [2*WIDTH-1:0] rsp_product_reg, rsp_product_next;
  logic               rsp_err_reg, rsp_err_next;

  logic               grant_found;
  logic [IDW-1:0]     grant_id;
  logic [NREQ-1:0]    ready_vec;
  logic [WIDTH-1:0]   a_slice [NREQ];
  logic [WIDTH-1:0]   b_slice [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign a_slice[gi]   = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_slice[gi]   = bus.req_b[gi*WIDTH +: WIDTH];
      assign ready_vec[gi] = (state_reg == IDLE) && grant_found && (grant_id == IDW'(gi));
    end
  endgenerate

  // Search downward from last+NREQ so the nearest requester after last is written last and wins.
  always_comb begin
    int             idx_i;
    logic [IDW-1:0] idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx_i       = 0;
    idx         = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx_i = int'(last_reg) + k;
      if (idx_i >= NREQ) idx_i = idx_i - NREQ;
      idx = IDW'(idx_i);
      if (bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_next        = last_reg;
    id_next          = id_reg;
    a_next           = a_reg;
    b_next           = b_reg;
    cnt_next         = cnt_reg;
    start_next       = 1'b0;
    rsp_valid_next   = rsp_valid_reg;
    rsp_id_next      = rsp_id_reg;
    rsp_product_next = rsp_product_reg;
    rsp_err_next     = rsp_err_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          last_next  = grant_id;
          id_next    = grant_id;
          a_next     = a_slice[grant_id];
          b_next     = b_slice[grant_id];
          start_next = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_next   = '0;
        state_next = BLANK;
      end
      // A done seen here belongs to the previous operation.
      BLANK: state_next = WAIT;
      WAIT: begin
        cnt_next = cnt_reg + CW'(1);
        if (mult_done) begin
          rsp_valid_next   = 1'b1;
          rsp_id_next      = id_reg;
          rsp_product_next = mult_product;
          rsp_err_next     = 1'b0;
          state_next       = RESP;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          rsp_valid_next   = 1'b1;
          rsp_id_next      = id_reg;
          rsp_product_next = '0;
          rsp_err_next     = 1'b1;
          state_next       = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg        <= IDW'(NREQ - 1);
      id_reg          <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      cnt_reg         <= '0;
      start_reg       <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_id_reg      <= '0;
      rsp_product_reg <= '0;
      rsp_err_reg     <= 1'b0;
    end else begin
      last_reg        <= last_next;
      id_reg          <= id_next;
      a_reg           <= a_next;
      b_reg           <= b_next;
      cnt_reg         <= cnt_next;
      start_reg       <= start_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_id_reg      <= rsp_id_next;
      rsp_product_reg <= rsp_product_next;
      rsp_err_reg     <= rsp_err_next;
    end
  end

  assign bus.req_ready   = ready_vec;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_id      = rsp_id_reg;
  assign bus.rsp_product = rsp_product_reg;
  assign bus.rsp_err     = rsp_err_reg;
  assign busy            = (state_reg != IDLE);
  assign mult_start      = start_reg;
  assign mult_a          = a_reg;
  assign mult_b          = b_reg;
endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: a behavioural multiplier model, a response scoreboard
// fed by the stimulus, and a monitor that pops it on every response handshake.
module tb_mult_sched;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, mult_start, mult_done;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] mult_product;

  mult_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  mult_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_done    (mult_done),
    .mult_product (mult_product)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] p;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   starts = 0;
  int   rdy2 = 0;
  bit   never_done = 1'b0;
  bit   stale = 1'b0;

  // Multiplier model: done pulse LAT+1 cycles after the start cycle; optional stale done.
  logic [7:0] ma, mb;
  int         mcnt;
  bit         mact;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_done    <= 1'b0;
      mult_product <= '0;
      ma <= '0; mb <= '0; mcnt <= 0; mact <= 1'b0;
    end else begin
      mult_done <= 1'b0;
      if (mult_start) begin
        ma <= mult_a; mb <= mult_b; mact <= 1'b1; mcnt <= 0;
        if (stale) begin
          mult_done    <= 1'b1;
          mult_product <= 16'hdead;
        end
      end else if (mact) begin
        mcnt <= mcnt + 1;
        if (mcnt + 1 == LAT) begin
          mact <= 1'b0;
          if (!never_done) begin
            mult_done    <= 1'b1;
            mult_product <= 16'(ma) * 16'(mb);
          end
        end
      end
    end
  end

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mult_start) starts++;
      if (bus.req_ready[2]) rdy2++;
      chk("ready_onehot0", longint'($onehot0(bus.req_ready)), 1);
      if (busy) chk("ready_idle_only", bus.req_ready, 0);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("rsp id=%0d product=%0d err=%0d (expected id=%0d product=%0d err=%0d)",
                   bus.rsp_id, bus.rsp_product, bus.rsp_err, e.id, e.p, e.err);
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_product", bus.rsp_product, e.p);
          chk("rsp_err", bus.rsp_err, e.err);
        end
      end
    end
  end

  task automatic arm(int i, int a, int b);
    bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic push(int id, int p, bit err);
    exp_t e;
    e.id = id; e.p = 16'(p); e.err = err;
    sb.push_back(e);
  endtask

  // Wait for a grant, check it, then let the handshake edge pass.
  task automatic take(int exp_id, bit keep);
    int n = 0;
    int got = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready == '0) begin
      chk("grant_timeout", 0, 1);
      return;
    end
    chk("grant_id", bus.req_ready, longint'(1) << exp_id);
    for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) got = k;
    $display("grant req=%0d", got);
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid[got] = 1'b0;
  endtask

  // Returns the cycle index (handshake = 0) at which rsp_valid is first seen.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 100);
    if (!bus.rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int s0, r0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_product", bus.rsp_product, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mult_start", mult_start, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin with all four requesters held valid.
    for (int i = 0; i < NREQ; i++) arm(i, i + 1, 10);
    push(0, 10, 0); push(1, 20, 0); push(2, 30, 0); push(3, 40, 0); push(0, 10, 0);
    take(0, 1); take(1, 0); take(2, 0); take(3, 0); take(0, 0);
    drain();

    // Single request from requester 2.
    s0 = starts; r0 = rdy2;
    arm(2, 7, 7); push(2, 49, 0);
    take(2, 0);
    wait_rsp(n);
    chk("single_latency", n, 7);
    drain();
    chk("single_start_pulses", starts - s0, 1);
    chk("single_ready2_cycles", rdy2 - r0, 1);

    // Backpressure: response held for 20 cycles while requester 3 waits.
    bus.rsp_ready = 1'b0;
    arm(1, 12, 11); push(1, 132, 0);
    take(1, 0);
    arm(3, 3, 5); push(3, 15, 0);
    wait_rsp(n);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_id", bus.rsp_id, 1);
      chk("bp_rsp_product", bus.rsp_product, 132);
      chk("bp_rsp_err", bus.rsp_err, 0);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_mult_start", mult_start, 0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_grant_accept_cycle", bus.req_ready, 0);
    @(negedge clk);
    chk("bp_next_grant", bus.req_ready, 8);
    @(posedge clk);
    #1;
    bus.req_valid[3] = 1'b0;
    drain();

    // Timeout, then a normal request.
    never_done = 1'b1;
    arm(0, 5, 6); push(0, 0, 1);
    take(0, 0);
    wait_rsp(n);
    chk("timeout_latency", n, 3 + TIMEOUT);
    drain();
    never_done = 1'b0;
    arm(1, 6, 9); push(1, 54, 0);
    take(1, 0);
    wait_rsp(n);
    chk("post_timeout_latency", n, 7);
    drain();

    // Stale done in BLANK must be ignored.
    stale = 1'b1;
    arm(2, 255, 255); push(2, 65025, 0);
    take(2, 0);
    drain();
    stale = 1'b0;

    // Reset while in WAIT: request from requester 0 is dropped.
    arm(0, 2, 2);
    take(0, 0);
    repeat (3) @(negedge clk);
    chk("mid_wait_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_id", bus.rsp_id, 0);
    chk("arst_rsp_product", bus.rsp_product, 0);
    chk("arst_rsp_err", bus.rsp_err, 0);
    chk("arst_mult_start", mult_start, 0);
    chk("arst_mult_a", mult_a, 0);
    chk("arst_mult_b", mult_b, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_rsp_after_reset", bus.rsp_valid, 0);
    @(posedge clk);
    #1;
    arm(1, 3, 3); arm(0, 4, 4);
    push(0, 16, 0); push(1, 9, 0);
    take(0, 0); take(1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
